// File: rtl/sseg_mux_ctrl.sv
// Time-multiplexed seven-segment controller: per-slot dead time, PWM brightness,
// blank/blink masks, leading-zero suppression and strobe-loaded shadow registers.
module sseg_mux_ctrl #(
    parameter int N_DIG     = 8,
    parameter int SLOT_CYC  = 6250,
    parameter int DEAD_CYC  = 64,
    parameter int BRIGHT_W  = 4,
    parameter int BLINK_CYC = 12500000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*N_DIG-1:0]    hex_flat,
    input  logic [N_DIG-1:0]      dp_in,
    input  logic [N_DIG-1:0]      blank_in,
    input  logic [N_DIG-1:0]      blink_en,
    input  logic                  lz_en,
    input  logic [BRIGHT_W-1:0]   bright,
    output logic [N_DIG-1:0]      an,
    output logic [7:0]            sseg
);

    localparam int SLOT_W  = $clog2(SLOT_CYC);
    localparam int DIG_W   = $clog2(N_DIG);
    localparam int BLINK_W = $clog2(BLINK_CYC);

    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SLOT_CYC - 1);
    localparam logic [SLOT_W-1:0]  DEAD_V     = SLOT_W'(DEAD_CYC);
    localparam logic [DIG_W-1:0]   DIG_LAST   = DIG_W'(N_DIG - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYC - 1);

    logic [SLOT_W-1:0]   slotCnt_q, slotCnt_d;
    logic [DIG_W-1:0]    digIdx_q, digIdx_d;
    logic [BLINK_W-1:0]  blinkCnt_q, blinkCnt_d;
    logic                blinkPhase_q, blinkPhase_d;

    logic [4*N_DIG-1:0]  hex_q;
    logic [N_DIG-1:0]    dp_q;
    logic [N_DIG-1:0]    blank_q;
    logic [N_DIG-1:0]    blink_q;

    logic [N_DIG-1:0]    an_q, an_d;
    logic [7:0]          sseg_q, sseg_d;

    logic [N_DIG-1:0]    nonZeroAbove;
    logic [N_DIG-1:0]    lzSuppress;
    logic [SLOT_W-1:0]   slotOff;
    logic [BRIGHT_W-1:0] pwm;
    logic                pwmOn;
    logic                inWindow;
    logic                drive;
    logic [3:0]          hexCur;
    logic [6:0]          segCur;

    function automatic logic [6:0] segDecode(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    // A digit is blank-suppressed when it and every more significant digit are zero.
    always_comb begin
        nonZeroAbove = '0;
        nonZeroAbove[N_DIG-1] = |hex_q[4*N_DIG-1 -: 4];
        for (int k = N_DIG - 2; k >= 0; k--) begin
            nonZeroAbove[k] = (|hex_q[4*k +: 4]) | nonZeroAbove[k+1];
        end
        lzSuppress    = ~nonZeroAbove;
        lzSuppress[0] = 1'b0;
        if (!lz_en) begin
            lzSuppress = '0;
        end
    end

    always_comb begin
        inWindow = (slotCnt_q >= DEAD_V);
        slotOff  = slotCnt_q - DEAD_V;
        pwm      = slotOff[BRIGHT_W-1:0];
        pwmOn    = (&bright) || (pwm < bright);
        drive    = inWindow && pwmOn && !blank_q[digIdx_q]
                   && !(blink_q[digIdx_q] && blinkPhase_q);
        hexCur   = hex_q[{digIdx_q, 2'b00} +: 4];
        segCur   = lzSuppress[digIdx_q] ? 7'h7F : segDecode(hexCur);

        an_d   = {N_DIG{1'b1}};
        sseg_d = 8'hFF;
        if (drive) begin
            an_d   = ~(N_DIG'(1) << digIdx_q);
            sseg_d = {dp_q[digIdx_q], segCur};
        end
    end

    always_comb begin
        slotCnt_d    = slotCnt_q + 1'b1;
        digIdx_d     = digIdx_q;
        blinkCnt_d   = blinkCnt_q + 1'b1;
        blinkPhase_d = blinkPhase_q;
        if (slotCnt_q == SLOT_LAST) begin
            slotCnt_d = '0;
            digIdx_d  = (digIdx_q == DIG_LAST) ? '0 : digIdx_q + 1'b1;
        end
        if (blinkCnt_q == BLINK_LAST) begin
            blinkCnt_d   = '0;
            blinkPhase_d = ~blinkPhase_q;
        end
    end

    // Reset leaves the display dark until software issues its first load.
    always_ff @(posedge clk) begin
        if (reset) begin
            slotCnt_q    <= '0;
            digIdx_q     <= '0;
            blinkCnt_q   <= '0;
            blinkPhase_q <= 1'b0;
            hex_q        <= '0;
            dp_q         <= '1;
            blank_q      <= '1;
            blink_q      <= '0;
            an_q         <= '1;
            sseg_q       <= 8'hFF;
        end else begin
            slotCnt_q    <= slotCnt_d;
            digIdx_q     <= digIdx_d;
            blinkCnt_q   <= blinkCnt_d;
            blinkPhase_q <= blinkPhase_d;
            an_q         <= an_d;
            sseg_q       <= sseg_d;
            if (load) begin
                hex_q   <= hex_flat;
                dp_q    <= dp_in;
                blank_q <= blank_in;
                blink_q <= blink_en;
            end
        end
    end

    assign an   = an_q;
    assign sseg = sseg_q;

endmodule

// File: tb/tb_sseg_mux_ctrl.sv
// Directed bench for sseg_mux_ctrl with a small scan-position reference model
// (N_DIG=4, SLOT_CYC=8, DEAD_CYC=2, BRIGHT_W=2, BLINK_CYC=64).
module tb_sseg_mux_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] hex_flat;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic [3:0]  blink_en;
    logic        lz_en;
    logic [1:0]  bright;
    logic [3:0]  an;
    logic [7:0]  sseg;

    int passCnt  = 0;
    int checkCnt = 0;

    int          slot, dig, blinkCnt, pSlot, pDig;
    logic        phase;
    logic [3:0]  shBlank, shBlink;
    logic [7:0]  expSeg  [4];
    logic [7:0]  pendSeg [4];
    logic [3:0]  expAnV;
    logic [7:0]  expSegV;

    always #5 clk = ~clk;

    sseg_mux_ctrl #(
        .N_DIG(4), .SLOT_CYC(8), .DEAD_CYC(2), .BRIGHT_W(2), .BLINK_CYC(64)
    ) dut (
        .clk(clk), .reset(reset), .load(load), .hex_flat(hex_flat),
        .dp_in(dp_in), .blank_in(blank_in), .blink_en(blink_en),
        .lz_en(lz_en), .bright(bright), .an(an), .sseg(sseg)
    );

    task automatic checkValue(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checkCnt++;
        assert (obs === exp) passCnt++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock edge; expected outputs come from the pre-edge model state.
    task automatic applyStimulus();
        int   pwm;
        logic drv;
        if (reset) begin
            expAnV  = 4'hF;
            expSegV = 8'hFF;
        end else begin
            pwm     = (slot - 2) & 3;
            drv     = (slot >= 2) && ((bright == 2'd3) || (pwm < int'(bright)))
                      && !shBlank[dig] && !(shBlink[dig] && phase);
            expAnV  = drv ? ~(4'b0001 << dig) : 4'hF;
            expSegV = drv ? expSeg[dig] : 8'hFF;
        end
        pSlot = slot;
        pDig  = dig;
        if (reset) begin
            slot = 0; dig = 0; blinkCnt = 0; phase = 1'b0;
            shBlank = 4'hF; shBlink = 4'h0;
            expSeg = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        end else begin
            if (slot == 7) begin slot = 0; dig = (dig + 1) % 4; end
            else slot++;
            if (blinkCnt == 63) begin blinkCnt = 0; phase = ~phase; end
            else blinkCnt++;
            if (load) begin
                shBlank = blank_in;
                shBlink = blink_en;
                expSeg  = pendSeg;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, "_an"}, {4'h0, an}, {4'h0, expAnV});
        checkValue({tag, "_sseg"}, sseg, expSegV);
    endtask

    task automatic waitFor(input int d, input int s, input string tag);
        int n = 0;
        do begin
            applyStimulus();
            checkOutput(tag);
            n++;
        end while (!(pDig == d && pSlot == s) && n < 100);
        if (!(pDig == d && pSlot == s)) begin
            checkCnt++;
            $error("[TB] FAIL %s_timeout: observed no slot %0d/%0d expected reached", tag, d, s);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; load = 1'b0; hex_flat = '0; dp_in = 4'hF; blank_in = 4'hF;
        blink_en = '0; lz_en = 1'b0; bright = 2'd3;
        slot = 0; dig = 0; blinkCnt = 0; phase = 1'b0; shBlank = 4'hF; shBlink = 4'h0;
        expSeg  = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        pendSeg = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};

        repeat (3) applyStimulus();
        checkValue("reset_an", {4'h0, an}, 8'h0F);
        checkValue("reset_sseg", sseg, 8'hFF);

        // Scenario 1: load 1234 right after reset, watch digit 0 then digit 1.
        reset = 1'b0; load = 1'b1; hex_flat = 16'h1234; dp_in = 4'b1110; blank_in = 4'h0;
        pendSeg = '{8'h19, 8'hB0, 8'hA4, 8'hF9};
        applyStimulus();
        load = 1'b0;
        checkValue("t1_dead0", {4'h0, an}, 8'h0F);
        applyStimulus();
        checkValue("t1_dead1", {4'h0, an}, 8'h0F);
        for (int i = 0; i < 6; i++) begin
            applyStimulus();
            checkValue("t1_d0_an", {4'h0, an}, 8'h0E);
            checkValue("t1_d0_sseg", sseg, 8'h19);
        end
        repeat (2) begin
            applyStimulus();
            checkOutput("t1_gap");
        end
        applyStimulus();
        checkValue("t1_d1_an", {4'h0, an}, 8'h0D);
        checkValue("t1_d1_sseg", sseg, 8'hB0);

        // Scenario 2: free run, one-hot-low anodes.
        for (int i = 0; i < 32; i++) begin
            applyStimulus();
            checkOutput("t2");
            checkValue("t2_onehot", {7'h0, ($countones(~an) <= 1)}, 8'h01);
        end

        // Scenario 3: leading-zero suppression on 0050.
        hex_flat = 16'h0050; dp_in = 4'hF; lz_en = 1'b1; load = 1'b1;
        pendSeg = '{8'hC0, 8'h92, 8'hFF, 8'hFF};
        applyStimulus();
        load = 1'b0;
        waitFor(3, 4, "t3_d3");
        checkValue("t3_d3_an", {4'h0, an}, 8'h07);
        checkValue("t3_d3_sseg", sseg, 8'hFF);
        waitFor(2, 4, "t3_d2");
        checkValue("t3_d2_an", {4'h0, an}, 8'h0B);
        checkValue("t3_d2_sseg", sseg, 8'hFF);
        waitFor(1, 4, "t3_d1");
        checkValue("t3_d1_sseg", sseg, 8'h92);
        waitFor(0, 4, "t3_d0");
        checkValue("t3_d0_sseg", sseg, 8'hC0);
        lz_en = 1'b0;
        expSeg = '{8'hC0, 8'h92, 8'hC0, 8'hC0};
        waitFor(3, 4, "t3_nolz");
        checkValue("t3_nolz_sseg", sseg, 8'hC0);

        // Scenario 4: brightness 1 lights only pwm==0 cycles; brightness 0 stays dark.
        bright = 2'd1;
        waitFor(0, 7, "t4_align");
        for (int s = 0; s < 8; s++) begin
            applyStimulus();
            checkOutput("t4_b1");
            checkValue("t4_b1_an", {4'h0, an}, (s == 2 || s == 6) ? 8'h0D : 8'h0F);
        end
        bright = 2'd0;
        repeat (64) begin
            applyStimulus();
            checkValue("t4_b0_an", {4'h0, an}, 8'h0F);
        end

        // Scenario 5: blink digit 0 across three blink half-periods from reset.
        bright = 2'd3;
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        hex_flat = 16'h1234; dp_in = 4'hF; blank_in = 4'h0; blink_en = 4'b0001;
        pendSeg = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        for (int c = 0; c < 192; c++) begin
            load = (c == 0);
            applyStimulus();
            checkOutput("t5");
            if (c >= 64 && c < 128) checkValue("t5_off_an0", {7'h0, an[0]}, 8'h01);
        end
        load = 1'b0;
        blink_en = 4'h0;
        load = 1'b1;
        applyStimulus();
        load = 1'b0;

        // Scenario 6: reset with simultaneous load mid-slot of digit 2.
        waitFor(2, 4, "t6_align");
        reset = 1'b1; load = 1'b1; hex_flat = 16'hFFFF; blank_in = 4'h0;
        applyStimulus();
        checkValue("t6_rst_an", {4'h0, an}, 8'h0F);
        checkValue("t6_rst_sseg", sseg, 8'hFF);
        reset = 1'b0; load = 1'b0;
        repeat (20) begin
            applyStimulus();
            checkOutput("t6_dark");
            checkValue("t6_dark_an", {4'h0, an}, 8'h0F);
        end
        hex_flat = 16'h1234; dp_in = 4'hF; blank_in = 4'h0; load = 1'b1;
        pendSeg = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        applyStimulus();
        load = 1'b0;
        waitFor(0, 2, "t6_resume");
        checkValue("t6_resume_an", {4'h0, an}, 8'h0E);
        checkValue("t6_resume_sseg", sseg, 8'h99);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
